// File: rtl/router_pkg.sv
// router_pkg: shared sizes, header field positions and the stored FIFO word layout
package router_pkg;
   localparam int FIFO_DEPTH = 16;
   localparam int DATA_W     = 8;
   localparam int ADDR_LSB   = 0;
   localparam int ADDR_MSB   = 1;
   localparam int LEN_LSB    = 2;
   localparam int LEN_MSB    = 7;
   typedef struct packed {
      logic       hdr;
      logic [7:0] data;
   } fifo_word_t;
endpackage

// File: rtl/router_fifo_ptr.sv
// router_fifo_ptr: wrap-bit read/write pointers with full and empty flags
module router_fifo_ptr #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        soft_reset,
   input  logic        wr_inc,
   input  logic        rd_inc,
   output logic [AW:0] wr_ptr,
   output logic [AW:0] rd_ptr,
   output logic        full,
   output logic        empty
);
   assign empty = wr_ptr == rd_ptr;
   assign full  = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
   // pointers clear on either reset and otherwise advance on accepted transfers
   always_ff @(posedge clock) begin
      if (reset || soft_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + (AW+1)'(wr_inc);
         rd_ptr <= rd_ptr + (AW+1)'(rd_inc);
      end
   end
endmodule

// File: rtl/router_fifo.sv
// router_fifo: per-destination packet FIFO with header tagging and packet-length tracking
import router_pkg::*;
module router_fifo #(
   parameter int DEPTH   = FIFO_DEPTH,
   parameter int WIDTH   = DATA_W,
   parameter int LEN_MSB = router_pkg::LEN_MSB
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   input  logic             read_enb,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = LEN_MSB - LEN_LSB + 2;
   logic [WIDTH:0]    mem [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [WIDTH:0]    rd_word;
   logic              wr_acc, rd_acc;
   assign wr_acc  = write_enb && !full && !soft_reset;
   assign rd_acc  = read_enb && !empty;
   assign rd_word = mem[rd_ptr[AW-1:0]];
   router_fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_ptr (
      .clock      (clock),
      .reset      (reset),
      .soft_reset (soft_reset),
      .wr_inc     (wr_acc),
      .rd_inc     (rd_acc),
      .wr_ptr     (wr_ptr),
      .rd_ptr     (rd_ptr),
      .full       (full),
      .empty      (empty)
   );
   // storage keeps the header tag alongside each byte; contents need no reset
   always_ff @(posedge clock) begin
      if (wr_acc) mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
   end
   // registered read data and the remaining payload+parity count of the current packet
   always_ff @(posedge clock) begin
      if (reset || soft_reset) begin
         data_out <= '0;
         count    <= '0;
      end else if (rd_acc) begin
         data_out <= rd_word[WIDTH-1:0];
         count    <= rd_word[WIDTH] ? CW'(rd_word[LEN_MSB:LEN_LSB]) + CW'(1)
                   : count != '0   ? count - CW'(1) : count;
      end else if (count == '0) begin
         data_out <= '0;
      end
   end
endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Per-destination packet FIFO of the 1x3 router; three instances sit directly downstream of the synchroniser.
- Each instance takes its one-hot write_enb bit and its soft_reset line.
- Returns full and empty, which the synchroniser uses for fifo_full and vld_out_N.
- Stores header, payload and parity bytes with a header tag, and tracks packet boundaries on the read side.

Parameters:
- DEPTH, 16, number of entries (power of two, at least 4).
- WIDTH, 8, data byte width.
- LEN_MSB, 7, MSB of the payload-length field in the header byte. The field is header[LEN_MSB:2].

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- soft_reset  in  1  synchronous flush from the synchroniser time-out.
- write_enb  in  1  write request (one bit of the synchroniser's write_enb).
- lfd_state  in  1  marks data_in as the header byte of a packet.
- data_in  in  WIDTH  byte to store.
- read_enb  in  1  read request from the output port.
- data_out  out  WIDTH  registered read data.
- full  out  1  DEPTH entries occupied.
- empty  out  1  zero entries occupied.

Behaviour:
- Storage: DEPTH x (WIDTH+1) array. Bit WIDTH holds the lfd_state value captured with the byte.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide, with the extra wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = address bits equal and wrap bits differ.
  - Both flags are combinational from the pointers.
- Priority order: reset, then soft_reset, then normal operation.
- Reset: pointers 0, packet counter 0, data_out 0, memory contents don't-care. Result: empty=1, full=0.
- soft_reset: same effect as reset on pointers, counter and data_out. Takes effect in the cycle it is sampled. Concurrent write and read in that cycle are dropped.
- Write accepted when write_enb && !full:
  - mem[wr_ptr] <= {lfd_state, data_in}, then wr_ptr increments.
  - A write while full is ignored; no overwrite, no error flag.
- Read accepted when read_enb && !empty:
  - data_out <= mem[rd_ptr][WIDTH-1:0], then rd_ptr increments.
  - One-cycle latency: data appears on the edge after read_enb is sampled.
- Packet counter, 7 bits (LEN_MSB-1 plus 1 spare bit):
  - On an accepted read of a tagged entry: count <= header[LEN_MSB:2] + 1, covering payload plus parity.
  - On an accepted read of an untagged entry with count > 0: count decrements.
  - A tagged read while count > 0 reloads the counter (new packet wins).
- data_out when no read is accepted: cleared to 0 if count == 0, otherwise held. So data_out returns to 0 one cycle after the parity byte, unless a new read is accepted.
- Simultaneous read and write:
  - Not full and not empty: both happen and occupancy is unchanged.
  - Full: only the read happens (write blocked by the full flag sampled that cycle).
  - Empty: only the write happens; the new data is not readable until the next cycle.
- Wrap-around: pointers roll over modulo 2*DEPTH with no special handling.
- No combinational path from data_in to data_out.

Decomposition:
- router_pkg holds:
  - FIFO_DEPTH = 16, DATA_W = 8.
  - Header field positions: ADDR_LSB = 0, ADDR_MSB = 1, LEN_LSB = 2, LEN_MSB = 7.
  - typedef fifo_word_t, a packed struct {logic hdr; logic [7:0] data}.
- One sub-module, router_fifo_ptr: a pointer/flag generator instantiated once per pointer pair. It produces wr_ptr, rd_ptr, full and empty.
- Storage and the packet counter stay in router_fifo.

Test Plan:
- Reset, then idle: empty=1, full=0, data_out=0. A read_enb pulse while empty leaves rd_ptr unchanged and data_out=0.
- Packet read-out:
  - Write header 0x06 (lfd_state=1), payload 0xA5, parity 0xA3, then read 3 cycles.
  - data_out = 0x06, 0xA5, 0xA3 on consecutive edges; count = 2, 1, 0.
  - data_out = 0x00 on the following edge; empty=1.
- Fill and overflow:
  - 16 writes of 0x10..0x1F give full=1.
  - A 17th write of 0xFF is ignored.
  - 16 reads return 0x10..0x1F in order, then empty=1.
- Full with simultaneous read+write:
  - Same cycle, write 0x55 and read: read returns the oldest byte and 0x55 is dropped; full=0 next cycle.
  - Next cycle, write+read: both accepted and full stays 0.
- soft_reset mid-packet:
  - Write header 0x0A and 2 payload bytes, read header, assert soft_reset for 1 cycle.
  - Next cycle: empty=1, data_out=0, count=0.
  - A new header 0x05 then reads back correctly.
- Wrap-around:
  - 40 interleaved write/read pairs, keeping occupancy between 1 and 3.
  - Read order matches write order across the pointer wrap; no spurious full or empty.
